pipe_register_file: RTL and testbench
=====================================

// Module: pipe_register_file
// PURPOSE
//  Parametrised integer register file for the pipelined RISC-V core.
//  - NUM_READ registered read ports with write-first bypass.
//  - Per-register busy scoreboard (reserve at issue, clear at writeback, flush on redirect).
//  - Handshaked debug read port.
//  Sits between decode (reads, reserves) and writeback (writes).
// PARAMETERS
//  XLEN      32          data width in bits
//  NREGS     32          register count; power of two, >=2; AW = $clog2(NREGS)
//  NUM_READ  2           number of read ports, 1..4
//  SP_INDEX  2           register index loaded with SP_RESET at reset
//  SP_RESET  32'h000000F8  stack-pointer reset value
// PORTS
//  clock       in   1              core clock; all state on posedge
//  reset       in   1              asynchronous, active-high
//  rd_addr     in   NUM_READ*AW    packed read addresses; port k at [k*AW +: AW]
//  rd_data     out  NUM_READ*XLEN  registered read data, packed the same way
//  rd_busy     out  NUM_READ       registered busy flag of the addressed register
//  wr_en       in   1              writeback strobe
//  wr_addr     in   AW             writeback address
//  wr_data     in   XLEN           writeback data
//  rsv_en      in   1              reserve strobe from issue
//  rsv_addr    in   AW             register to mark busy
//  flush       in   1              clear all busy bits (pipeline redirect)
//  busy_count  out  AW+1           number of currently busy registers
//  dbg_req     in   1              debug read request, one-cycle pulse
//  dbg_addr    in   AW             debug read address
//  dbg_valid   out  1              one-cycle pulse, dbg_data valid
//  dbg_data    out  XLEN           debug read data, held until the next dbg_valid
// BEHAVIOUR
//  - Reset (async): all r[i] = 0 except r[SP_INDEX] = SP_RESET; busy = 0;
//    rd_data = 0; rd_busy = 0; busy_count = 0; dbg_valid = 0; dbg_data = 0.
//    Reset mid-operation discards any in-flight reserve or debug request.
//  - r[0]: reads always return 0; writes, reserves and busy on r[0] are ignored.
//  - Write: wr_en && wr_addr != 0 -> r[wr_addr] = wr_data at the edge;
//    clears busy[wr_addr].
//  - Read: latency 1. Port k samples rd_addr at the edge. If that edge writes
//    the same address, rd_data returns wr_data (write-first bypass);
//    otherwise r[rd_addr].
//  - rd_busy[k]: the post-edge busy value of rd_addr[k], using the priority below.
//  - Busy next-state, highest priority first:
//      1. rsv_en sets busy[rsv_addr];
//      2. flush clears all busy bits;
//      3. wr_en clears busy[wr_addr].
//    So reserve + write to the same address leaves busy = 1, and flush +
//    reserve leaves exactly busy[rsv_addr] = 1.
//  - busy_count: registered popcount of the busy vector after the edge.
//    Range 0..NREGS-1; never wraps.
//  - Debug: dbg_req sampled at edge N gives dbg_valid = 1 and dbg_data = r[dbg_addr]
//    at edge N+1, with the same write-first bypass.
//    Back-to-back requests are accepted every cycle.
//    dbg_valid = 0 in cycles without a request.
//  - Out-of-range addresses cannot occur (NREGS is a power of two).
// STRUCTURE
//  - Package regfile_pkg:
//      - XLEN_DEFAULT, NREGS_DEFAULT, SP_INDEX_DEFAULT, SP_RESET_DEFAULT;
//      - function clog2;
//      - typedef reg_addr_t.
//  - One sub-module, regfile_scoreboard: busy vector, priority update, busy_count.
//    Ports: clock, reset, rsv_en/addr, flush, wr_en/addr, busy, busy_count.
//  - Storage array, read ports, bypass and debug path live in the top module;
//    read ports are built with a generate loop over NUM_READ.
// TESTING
//  1. Reset, then read r2 and r5:
//     rd_data = 0x000000F8 and 0; busy_count = 0; dbg_valid = 0.
//  2. Write r7 = 0xDEADBEEF while port 0 reads r7 in the same cycle:
//     rd_data[0] = 0xDEADBEEF next cycle. Write r0 = 0x1234: reads of r0 return 0.
//  3. Reserve r3, r4, then write r3:
//     busy_count = 1, 2, 1; rd_busy of r3 = 0 and of r4 = 1.
//     Reserve r0: busy_count unchanged.
//  4. Reserve r9 and write r9 in the same cycle: busy stays 1.
//     Flush + reserve r5 with r9, r4 busy: busy_count = 1, only r5 busy.
//  5. dbg_req on r2, r7 in consecutive cycles: dbg_valid high 2 cycles,
//     dbg_data = 0xF8 then 0xDEADBEEF. Assert reset mid-burst: dbg_valid = 0 at once.
//  6. NUM_READ = 4, NREGS = 16: all ports read distinct registers in one cycle,
//     all values correct.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, helpers and types for the pipelined integer register file.
package regfile_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam int          NREGS_DEFAULT    = 32;
  localparam int          SP_INDEX_DEFAULT = 2;
  localparam logic [31:0] SP_RESET_DEFAULT = 32'h0000_00F8;

  // Ceiling log2, usable in parameter expressions (value >= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  typedef logic [clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve at issue, clear at writeback,
// flush on redirect, with a registered count of busy registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  localparam int AW   = clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_count
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;

  // Next busy vector; later assignments win, so the lowest priority comes first.
  always_comb begin
    busy_next = busy_reg;
    if (wr_en) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (flush) begin
      busy_next = '0;
    end
    if (rsv_en) begin
      busy_next[rsv_addr] = 1'b1;
    end
    // r0 is hardwired to zero and can never be outstanding.
    busy_next[0] = 1'b0;
  end

  // Popcount of the post-edge vector so the count is registered alongside it.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      count_next = count_next + (AW+1)'(busy_next[i]);
    end
  end

  // Busy vector and count state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_reg  <= '0;
      count_reg <= '0;
    end else begin
      busy_reg  <= busy_next;
      count_reg <= count_next;
    end
  end

  assign busy       = busy_reg;
  assign busy_count = count_reg;

endmodule

// File: rtl/pipe_register_file.sv
// Integer register file for the pipelined core: registered read ports with
// write-first bypass, busy scoreboard and a one-cycle debug read port.
module pipe_register_file
  import regfile_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              NREGS    = NREGS_DEFAULT,
  parameter int              NUM_READ = 2,
  parameter int              SP_INDEX = SP_INDEX_DEFAULT,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'(SP_RESET_DEFAULT),
  localparam int             AW       = clog2(NREGS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_READ*AW-1:0]   rd_addr,
  output logic [NUM_READ*XLEN-1:0] rd_data,
  output logic [NUM_READ-1:0]      rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic                     flush,
  output logic [AW:0]              busy_count,
  input  logic                     dbg_req,
  input  logic [AW-1:0]            dbg_addr,
  output logic                     dbg_valid,
  output logic [XLEN-1:0]          dbg_data
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_live;

  // Writes to r0 are dropped everywhere, including the bypass paths.
  assign wr_live = wr_en && (wr_addr != '0);

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .busy_count (busy_count)
  );

  // Register storage; reset loads the stack pointer, everything else is zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data_next;
      logic [XLEN-1:0] data_reg;
      logic            busy_next;
      logic            busy_reg;

      assign addr = rd_addr[gi*AW +: AW];

      // Read value with write-first bypass, and the addressed busy bit as it
      // will be after this edge (same priority as the scoreboard).
      always_comb begin
        data_next = regs[addr];
        if (wr_live && (wr_addr == addr)) begin
          data_next = wr_data;
        end
        if (addr == '0) begin
          data_next = '0;
        end
        busy_next = busy[addr];
        if (wr_en && (wr_addr == addr)) begin
          busy_next = 1'b0;
        end
        if (flush) begin
          busy_next = 1'b0;
        end
        if (rsv_en && (rsv_addr == addr)) begin
          busy_next = 1'b1;
        end
        if (addr == '0) begin
          busy_next = 1'b0;
        end
      end

      // Registered read port outputs.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else begin
          data_reg <= data_next;
          busy_reg <= busy_next;
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = data_reg;
      assign rd_busy[gi]              = busy_reg;
    end
  endgenerate

  logic [XLEN-1:0] dbg_data_next;
  logic [XLEN-1:0] dbg_data_reg;
  logic            dbg_valid_reg;

  // Debug read value, bypassed the same way as the normal read ports.
  always_comb begin
    dbg_data_next = regs[dbg_addr];
    if (wr_live && (wr_addr == dbg_addr)) begin
      dbg_data_next = wr_data;
    end
    if (dbg_addr == '0) begin
      dbg_data_next = '0;
    end
  end

  // Debug response: valid pulses for one cycle per request, data is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dbg_valid_reg <= 1'b0;
      dbg_data_reg  <= '0;
    end else begin
      dbg_valid_reg <= dbg_req;
      if (dbg_req) begin
        dbg_data_reg <= dbg_data_next;
      end
    end
  end

  assign dbg_valid = dbg_valid_reg;
  assign dbg_data  = dbg_data_reg;

endmodule

// File: tb/tb_pipe_register_file.sv
// Directed bench for pipe_register_file: a vector table for the default
// configuration plus hand-written reset, saturation and 4-port sequences.
module tb_pipe_register_file;
  import regfile_pkg::*;

  logic clock;
  logic reset;

  // Default instance: XLEN 32, NREGS 32, NUM_READ 2.
  reg_addr_t   rd_addr0, rd_addr1;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  reg_addr_t   wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  reg_addr_t   rsv_addr;
  logic        flush;
  logic [5:0]  busy_count;
  logic        dbg_req;
  reg_addr_t   dbg_addr;
  logic        dbg_valid;
  logic [31:0] dbg_data;

  pipe_register_file u_dut (
    .clock      (clock),
    .reset      (reset),
    .rd_addr    ({rd_addr1, rd_addr0}),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .flush      (flush),
    .busy_count (busy_count),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_valid  (dbg_valid),
    .dbg_data   (dbg_data)
  );

  // Small instance: NREGS 16, NUM_READ 4.
  logic [15:0]  s_rd_addr;
  logic [127:0] s_rd_data;
  logic [3:0]   s_rd_busy;
  logic         s_wr_en;
  logic [3:0]   s_wr_addr;
  logic [31:0]  s_wr_data;
  logic [4:0]   s_busy_count;
  logic         s_dbg_valid;
  logic [31:0]  s_dbg_data;

  pipe_register_file #(
    .NREGS    (16),
    .NUM_READ (4)
  ) u_dut4 (
    .clock      (clock),
    .reset      (reset),
    .rd_addr    (s_rd_addr),
    .rd_data    (s_rd_data),
    .rd_busy    (s_rd_busy),
    .wr_en      (s_wr_en),
    .wr_addr    (s_wr_addr),
    .wr_data    (s_wr_data),
    .rsv_en     (1'b0),
    .rsv_addr   (4'd0),
    .flush      (1'b0),
    .busy_count (s_busy_count),
    .dbg_req    (1'b0),
    .dbg_addr   (4'd0),
    .dbg_valid  (s_dbg_valid),
    .dbg_data   (s_dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        fl;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        dq;
    logic [4:0]  da;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [1:0]  e_busy;
    logic [5:0]  e_cnt;
    logic        e_dv;
    logic [31:0] e_dd;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    rd_addr0 = '0; rd_addr1 = '0;
    dbg_req = 1'b0; dbg_addr = '0;
    s_rd_addr = '0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
  endtask

  // Inputs change #1 after the rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    // we wa wd          re ra fl a0 a1 dq da  d0            d1            busy   cnt dv dd
    vecs[0]  = '{0, 0, 32'h0,        0, 0, 0, 2, 5, 0, 0, 32'hF8,       32'h0,        2'b00, 0, 0, 32'h0};
    vecs[1]  = '{1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 2, 0, 0, 32'hDEADBEEF, 32'hF8,       2'b00, 0, 0, 32'h0};
    vecs[2]  = '{1, 0, 32'h1234,     0, 0, 0, 0, 7, 0, 0, 32'h0,        32'hDEADBEEF, 2'b00, 0, 0, 32'h0};
    vecs[3]  = '{0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0, 0, 32'h0};
    vecs[4]  = '{0, 0, 32'h0,        1, 3, 0, 3, 4, 0, 0, 32'h0,        32'h0,        2'b01, 1, 0, 32'h0};
    vecs[5]  = '{0, 0, 32'h0,        1, 4, 0, 3, 4, 0, 0, 32'h0,        32'h0,        2'b11, 2, 0, 32'h0};
    vecs[6]  = '{1, 3, 32'h33,       0, 0, 0, 3, 4, 0, 0, 32'h33,       32'h0,        2'b10, 1, 0, 32'h0};
    vecs[7]  = '{0, 0, 32'h0,        1, 0, 0, 0, 4, 0, 0, 32'h0,        32'h0,        2'b10, 1, 0, 32'h0};
    vecs[8]  = '{1, 9, 32'h99,       1, 9, 0, 9, 4, 0, 0, 32'h99,       32'h0,        2'b11, 2, 0, 32'h0};
    vecs[9]  = '{0, 0, 32'h0,        1, 5, 1, 5, 9, 0, 0, 32'h0,        32'h99,       2'b01, 1, 0, 32'h0};
    vecs[10] = '{0, 0, 32'h0,        0, 0, 0, 4, 9, 1, 2, 32'h0,        32'h99,       2'b00, 1, 1, 32'hF8};
    vecs[11] = '{0, 0, 32'h0,        0, 0, 0, 4, 9, 1, 7, 32'h0,        32'h99,       2'b00, 1, 1, 32'hDEADBEEF};
    vecs[12] = '{0, 0, 32'h0,        0, 0, 0, 4, 9, 0, 0, 32'h0,        32'h99,       2'b00, 1, 0, 32'hDEADBEEF};
    vecs[13] = '{1, 9, 32'hABCD,     0, 0, 0, 9, 5, 1, 9, 32'hABCD,     32'h0,        2'b10, 1, 1, 32'hABCD};
    vecs[14] = '{1, 5, 32'h55,       0, 0, 0, 5, 2, 0, 0, 32'h55,       32'hF8,       2'b00, 0, 0, 32'hABCD};
    vecs[15] = '{0, 0, 32'h0,        1, 6, 0, 6, 7, 0, 0, 32'h0,        32'hDEADBEEF, 2'b01, 1, 0, 32'hABCD};
    vecs[16] = '{1, 6, 32'h66,       0, 0, 1, 6, 6, 0, 0, 32'h66,       32'h66,       2'b00, 0, 0, 32'hABCD};

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    check("reset.rd_data0", rd_data[31:0], 32'h0);
    check("reset.rd_data1", rd_data[63:32], 32'h0);
    check("reset.busy_count", busy_count, 6'd0);
    check("reset.dbg_valid", dbg_valid, 1'b0);
    check("reset.dbg_data", dbg_data, 32'h0);

    // Table-driven vectors on the default instance.
    for (int i = 0; i < NVEC; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rsv_en = vecs[i].re; rsv_addr = vecs[i].ra; flush = vecs[i].fl;
      rd_addr0 = vecs[i].a0; rd_addr1 = vecs[i].a1;
      dbg_req = vecs[i].dq; dbg_addr = vecs[i].da;
      step();
      $display("txn %0d: d0=%h d1=%h busy=%b cnt=%0d dv=%b dd=%h",
               i, rd_data[31:0], rd_data[63:32], rd_busy, busy_count, dbg_valid, dbg_data);
      check($sformatf("v%0d.rd_data0", i), rd_data[31:0], vecs[i].e_d0);
      check($sformatf("v%0d.rd_data1", i), rd_data[63:32], vecs[i].e_d1);
      check($sformatf("v%0d.rd_busy", i), rd_busy, vecs[i].e_busy);
      check($sformatf("v%0d.busy_count", i), busy_count, vecs[i].e_cnt);
      check($sformatf("v%0d.dbg_valid", i), dbg_valid, vecs[i].e_dv);
      check($sformatf("v%0d.dbg_data", i), dbg_data, vecs[i].e_dd);
    end
    idle_inputs();

    // Reserve every register: the count saturates at NREGS-1 without wrapping.
    for (int i = 1; i < 32; i++) begin
      rsv_en = 1'b1; rsv_addr = reg_addr_t'(i);
      step();
    end
    $display("txn fill: cnt=%0d", busy_count);
    check("fill.busy_count", busy_count, 6'd31);
    rsv_addr = 5'd1; rd_addr0 = 5'd1; rd_addr1 = 5'd31;
    step();
    $display("txn refill: cnt=%0d busy=%b", busy_count, rd_busy);
    check("refill.busy_count", busy_count, 6'd31);
    check("refill.rd_busy", rd_busy, 2'b11);
    rsv_en = 1'b0; flush = 1'b1;
    step();
    $display("txn flush: cnt=%0d busy=%b", busy_count, rd_busy);
    check("flush.busy_count", busy_count, 6'd0);
    check("flush.rd_busy", rd_busy, 2'b00);
    idle_inputs();

    // Debug burst interrupted by an asynchronous reset.
    dbg_req = 1'b1; dbg_addr = 5'd2;
    step();
    $display("txn dbg r2: dv=%b dd=%h", dbg_valid, dbg_data);
    check("burst.dbg_valid0", dbg_valid, 1'b1);
    check("burst.dbg_data0", dbg_data, 32'hF8);
    dbg_addr = 5'd7; rsv_en = 1'b1; rsv_addr = 5'd3;
    #2;
    reset = 1'b1;
    #1;
    $display("txn async reset: dv=%b dd=%h cnt=%0d", dbg_valid, dbg_data, busy_count);
    check("areset.dbg_valid", dbg_valid, 1'b0);
    check("areset.dbg_data", dbg_data, 32'h0);
    check("areset.rd_data0", rd_data[31:0], 32'h0);
    step();
    idle_inputs();
    reset = 1'b0;
    rd_addr0 = 5'd7; rd_addr1 = 5'd2;
    step();
    $display("txn post-reset: d0=%h d1=%h cnt=%0d dv=%b", rd_data[31:0], rd_data[63:32], busy_count, dbg_valid);
    check("post.rd_data0", rd_data[31:0], 32'h0);
    check("post.rd_data1", rd_data[63:32], 32'hF8);
    check("post.busy_count", busy_count, 6'd0);
    check("post.dbg_valid", dbg_valid, 1'b0);
    idle_inputs();

    // Four-port instance: fill r1..r3, then read four registers while r4 is written.
    for (int i = 1; i < 4; i++) begin
      s_wr_en = 1'b1; s_wr_addr = 4'(i); s_wr_data = 32'(i * 32'h11);
      step();
    end
    s_wr_addr = 4'd4; s_wr_data = 32'h44;
    s_rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    step();
    $display("txn 4port a: %h", s_rd_data);
    check("p4a.port0", s_rd_data[31:0], 32'h11);
    check("p4a.port1", s_rd_data[63:32], 32'h22);
    check("p4a.port2", s_rd_data[95:64], 32'h33);
    check("p4a.port3", s_rd_data[127:96], 32'h44);
    s_wr_en = 1'b0;
    s_rd_addr = {4'd1, 4'd2, 4'd15, 4'd0};
    step();
    $display("txn 4port b: %h busy=%b", s_rd_data, s_rd_busy);
    check("p4b.port0", s_rd_data[31:0], 32'h0);
    check("p4b.port1", s_rd_data[63:32], 32'h0);
    check("p4b.port2", s_rd_data[95:64], 32'h22);
    check("p4b.port3", s_rd_data[127:96], 32'h11);
    check("p4b.rd_busy", s_rd_busy, 4'b0000);
    check("p4b.busy_count", s_busy_count, 5'd0);
    check("p4b.dbg_valid", s_dbg_valid, 1'b0);
    check("p4b.dbg_data", s_dbg_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
